// File: rtl/gf180mcu_ocd_io__supply_seq_pkg.sv
// Shared types and width helpers for the I/O-ring supply sequencer.
package gf180mcu_ocd_io_seq_pkg;

    // Sequencer states; BUSY is asserted in S_RAMP, S_GAP and S_DOWN.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_GAP   = 3'd2,
        S_ON    = 3'd3,
        S_DOWN  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    // Width of a domain index; at least one bit even for a single domain.
    function automatic int dw_f(input int n_dom);
        return (n_dom <= 1) ? 1 : $clog2(n_dom);
    endfunction

    // Width of the shared step timer, sized for the longer of timeout and gap.
    function automatic int tw_f(input int tmo_cyc, input int gap_cyc);
        int longest;
        longest = (tmo_cyc > gap_cyc) ? tmo_cyc : gap_cyc;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_ocd_io__supply_seq_if.sv
// Power-manager / supply-pad bundle seen by the sequencer.
interface gf180mcu_ocd_io__supply_seq_if #(
    parameter int N_DOM = 4
) ();
    import gf180mcu_ocd_io_seq_pkg::*;

    localparam int DW = dw_f(N_DOM);

    logic             start;
    logic             stop;
    logic             clr_fault;
    logic [N_DOM-1:0] pg;
    logic [N_DOM-1:0] en;
    logic             ready;
    logic             fault;
    logic [DW-1:0]    fault_dom;
    logic             busy;

    // Power manager plus detectors: drive requests and raw power-good.
    modport master (
        output start, stop, clr_fault, pg,
        input  en, ready, fault, fault_dom, busy
    );

    // Sequencer side.
    modport slave (
        input  start, stop, clr_fault, pg,
        output en, ready, fault, fault_dom, busy
    );

endinterface

// File: rtl/gf180mcu_ocd_io__pg_debounce.sv
// Power-good conditioning for one domain: 2-flop synchroniser and a
// saturating run-length counter. pg_ok needs DEB_CYC consecutive synced-high
// samples to rise and drops on the first synced-low sample.
module gf180mcu_ocd_io__pg_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic pg,
    output logic pg_ok
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Synchronise raw PG and count consecutive high samples.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the previous stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            pg_ok <= 1'b0;
        end else begin
            sync1 <= pg;
            sync2 <= sync1;
            if (!sync2) begin
                cnt   <= '0;
                pg_ok <= 1'b0;
            end else if (cnt != CW'(DEB_CYC)) begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(DEB_CYC - 1)) pg_ok <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/gf180mcu_ocd_io__supply_seq.sv
// Power-up/power-down sequencer for N_DOM pad supply domains. Domains come up
// in ascending order gated on debounced power-good, go down in descending
// order, and any timeout or brown-out latches a sticky fault that drops all.
module gf180mcu_ocd_io__supply_seq
    import gf180mcu_ocd_io_seq_pkg::*;
#(
    parameter int N_DOM   = 4,
    parameter int DEB_CYC = 16,
    parameter int TMO_CYC = 1024,
    parameter int GAP_CYC = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    gf180mcu_ocd_io__supply_seq_if.slave   bus
);

    localparam int DW = dw_f(N_DOM);
    localparam int TW = tw_f(TMO_CYC, GAP_CYC);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYC - 1);

    state_t           state;
    logic [DW-1:0]    idx;
    logic [TW-1:0]    timer;
    logic [N_DOM-1:0] en_q;
    logic             ready_q;
    logic             fault_q;
    logic [DW-1:0]    fault_dom_q;
    logic             busy_q;

    logic [N_DOM-1:0] pg_ok;
    logic [N_DOM-1:0] idx_bit;
    logic             idx_last;
    logic             lost;
    logic [DW-1:0]    lost_dom;

    for (genvar g = 0; g < N_DOM; g++) begin : g_deb
        gf180mcu_ocd_io__pg_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk    (clk),
            .resetn (resetn),
            .pg     (bus.pg[g]),
            .pg_ok  (pg_ok[g])
        );
    end

    assign idx_bit  = N_DOM'(1) << idx;
    assign idx_last = (idx == DW'(N_DOM - 1));

    // Find the lowest enabled domain that has lost power-good.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        lost     = 1'b0;
        lost_dom = '0;
        for (int j = N_DOM - 1; j >= 0; j--) begin
            if (j <= int'(idx) && !pg_ok[j]) begin
                lost     = 1'b1;
                lost_dom = DW'(j);
            end
        end
    end

    // Sequencer FSM with registered outputs; the timer clears on every step.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= S_IDLE;
            idx         <= '0;
            timer       <= '0;
            en_q        <= '0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
            fault_dom_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.stop && !fault_q) begin
                        state  <= S_RAMP;
                        idx    <= '0;
                        timer  <= '0;
                        en_q   <= N_DOM'(1);
                        busy_q <= 1'b1;
                    end
                end
                S_RAMP: begin
                    if (bus.stop) begin
                        state  <= S_DOWN;
                        timer  <= '0;
                        en_q   <= en_q & ~idx_bit;
                    end else if (pg_ok[idx]) begin
                        timer <= '0;
                        if (idx_last) begin
                            state   <= S_ON;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (timer == TMO_LAST) begin
                        state       <= S_FAULT;
                        timer       <= '0;
                        en_q        <= '0;
                        fault_q     <= 1'b1;
                        fault_dom_q <= idx;
                        busy_q      <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_GAP: begin
                    if (bus.stop) begin
                        state <= S_DOWN;
                        timer <= '0;
                        en_q  <= en_q & ~idx_bit;
                    end else if (timer == GAP_LAST) begin
                        state <= S_RAMP;
                        timer <= '0;
                        idx   <= idx + DW'(1);
                        en_q  <= en_q | (idx_bit << 1);
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_ON: begin
                    if (lost) begin
                        state       <= S_FAULT;
                        en_q        <= '0;
                        ready_q     <= 1'b0;
                        fault_q     <= 1'b1;
                        fault_dom_q <= lost_dom;
                    end else if (bus.stop) begin
                        state   <= S_DOWN;
                        timer   <= '0;
                        en_q    <= en_q & ~idx_bit;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_DOWN: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        if (idx == '0) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            idx  <= idx - DW'(1);
                            en_q <= en_q & ~(idx_bit >> 1);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_FAULT: begin
                    if (bus.clr_fault && !bus.start) begin
                        state       <= S_IDLE;
                        idx         <= '0;
                        fault_q     <= 1'b0;
                        fault_dom_q <= '0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    idx     <= '0;
                    timer   <= '0;
                    en_q    <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en        = en_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.fault_dom = fault_dom_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_gf180mcu_ocd_io__supply_seq.sv
// Directed bench for the supply sequencer (N_DOM=3, DEB_CYC=4, TMO_CYC=64, GAP_CYC=2).
module tb_gf180mcu_ocd_io__supply_seq;

    localparam int N_DOM = 3;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_vec = 0;
    int   n_miss = 0;

    gf180mcu_ocd_io__supply_seq_if #(.N_DOM(N_DOM)) bus ();

    gf180mcu_ocd_io__supply_seq #(
        .N_DOM   (N_DOM),
        .DEB_CYC (4),
        .TMO_CYC (64),
        .GAP_CYC (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; inputs change and outputs are read 1 ns after the edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full power-up; each PG rises 10 cycles after its enable.
    // PG set after edge E: sync at E+1/E+2, PG_OK at E+6, GAP at E+7, next EN at E+9.
    task automatic bring_up(input string tag);
        logic [2:0] masks [4];
        masks[0] = 3'b000; masks[1] = 3'b001; masks[2] = 3'b011; masks[3] = 3'b111;
        bus.start = 1'b1;
        step();
        check({tag, "_en0"}, 32'(bus.en), 32'(masks[1]));
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        for (int k = 0; k < N_DOM; k++) begin
            step(9);
            bus.pg[k] = 1'b1;
            if (k < N_DOM - 1) begin
                step(8);
                check({tag, "_hold"}, 32'(bus.en), 32'(masks[k+1]));
                step(1);
                check({tag, "_next"}, 32'(bus.en), 32'(masks[k+2]));
            end else begin
                step(6);
                check({tag, "_rdy_early"}, 32'(bus.ready), 32'd0);
                step(1);
                check({tag, "_ready"}, 32'(bus.ready), 32'd1);
                check({tag, "_en_all"}, 32'(bus.en), 32'(masks[3]));
                check({tag, "_busy_on"}, 32'(bus.busy), 32'd0);
                check({tag, "_nofault"}, 32'(bus.fault), 32'd0);
            end
        end
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.clr_fault = 1'b0;
        bus.pg = '0;
        step(5);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.clr_fault = 1'b0;
        bus.pg = '0;

        // Reset state
        step(3);
        resetn = 1'b1;
        step();
        check("rst_en", 32'(bus.en), 32'd0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_fault", 32'(bus.fault), 32'd0);
        check("rst_dom", 32'(bus.fault_dom), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);

        // 1 Normal power-up
        bring_up("up1");

        // 4 Brown-out in ON: PG[2] and PG[0] low for one cycle -> fault at E+4
        bus.pg = 3'b010;
        step();
        bus.pg = 3'b111;
        step(2);
        check("bo_pre_fault", 32'(bus.fault), 32'd0);
        check("bo_pre_en", 32'(bus.en), 32'h7);
        step();
        check("bo_fault", 32'(bus.fault), 32'd1);
        check("bo_dom", 32'(bus.fault_dom), 32'd0);
        check("bo_en", 32'(bus.en), 32'd0);
        check("bo_ready", 32'(bus.ready), 32'd0);
        check("bo_busy", 32'(bus.busy), 32'd0);
        step(10);
        check("bo_sticky", 32'(bus.fault), 32'd1);
        bus.start = 1'b1;
        bus.clr_fault = 1'b1;
        step();
        check("bo_clr_ign", 32'(bus.fault), 32'd1);
        bus.start = 1'b0;
        step();
        check("bo_clr", 32'(bus.fault), 32'd0);
        check("bo_clr_busy", 32'(bus.busy), 32'd0);
        idle_inputs();

        // 2 Timeout on domain 1
        bus.start = 1'b1;
        step();
        check("to_en0", 32'(bus.en), 32'd1);
        step(9);
        bus.pg[0] = 1'b1;
        step(9);
        check("to_en1", 32'(bus.en), 32'd3);
        step(63);
        check("to_pre_fault", 32'(bus.fault), 32'd0);
        check("to_pre_en", 32'(bus.en), 32'd3);
        step();
        check("to_fault", 32'(bus.fault), 32'd1);
        check("to_dom", 32'(bus.fault_dom), 32'd1);
        check("to_en", 32'(bus.en), 32'd0);
        bus.clr_fault = 1'b1;
        step();
        check("to_clr_ign", 32'(bus.fault), 32'd1);
        check("to_clr_ign_dom", 32'(bus.fault_dom), 32'd1);
        bus.start = 1'b0;
        step();
        check("to_clr", 32'(bus.fault), 32'd0);
        check("to_clr_dom", 32'(bus.fault_dom), 32'd0);
        idle_inputs();

        // 3 Debounce: 3-cycle glitch must not advance, stable rise advances at E+9
        bus.start = 1'b1;
        step();
        check("db_en0", 32'(bus.en), 32'd1);
        bus.pg[0] = 1'b1;
        step(3);
        bus.pg[0] = 1'b0;
        step(12);
        check("db_glitch", 32'(bus.en), 32'd1);
        bus.pg[0] = 1'b1;
        step(8);
        check("db_hold", 32'(bus.en), 32'd1);
        step();
        check("db_adv", 32'(bus.en), 32'd3);

        // 5b STOP during RAMP of domain 1 -> 001, then 000, then IDLE
        bus.stop = 1'b1;
        step();
        check("sr_en1", 32'(bus.en), 32'd1);
        check("sr_busy", 32'(bus.busy), 32'd1);
        step(2);
        check("sr_en0", 32'(bus.en), 32'd0);
        check("sr_busy2", 32'(bus.busy), 32'd1);
        step(2);
        check("sr_idle", 32'(bus.busy), 32'd0);
        step();
        check("sr_stop_wins", 32'(bus.en), 32'd0);
        idle_inputs();

        // 5a Ordered power-down from ON
        bring_up("up2");
        bus.stop = 1'b1;
        step();
        check("dn_en2", 32'(bus.en), 32'd3);
        check("dn_ready", 32'(bus.ready), 32'd0);
        check("dn_busy", 32'(bus.busy), 32'd1);
        step(2);
        check("dn_en1", 32'(bus.en), 32'd1);
        step(2);
        check("dn_en0", 32'(bus.en), 32'd0);
        check("dn_busy0", 32'(bus.busy), 32'd1);
        step(2);
        check("dn_idle", 32'(bus.busy), 32'd0);
        check("dn_nofault", 32'(bus.fault), 32'd0);
        idle_inputs();

        // 6 Reset mid-RAMP
        bus.start = 1'b1;
        step();
        check("rr_en0", 32'(bus.en), 32'd1);
        step(5);
        resetn = 1'b0;
        step();
        check("rr_en", 32'(bus.en), 32'd0);
        check("rr_busy", 32'(bus.busy), 32'd0);
        check("rr_fault", 32'(bus.fault), 32'd0);
        check("rr_ready", 32'(bus.ready), 32'd0);
        bus.start = 1'b0;
        resetn = 1'b1;
        step(3);
        check("rr_after_en", 32'(bus.en), 32'd0);
        check("rr_after_fault", 32'(bus.fault), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
